// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one full round per clock with on-the-fly
// key expansion, valid/ready handshake on both sides. State, key and output use
// column-major packing: word c = bits [127-32c -: 32], row 0 in the top byte.

// Forward AES S-box: multiplicative inverse in GF(2^8) (x^254), then affine map.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   logic [7:0] pw;
   logic [7:0] inv;

   // Inverse via square-and-multiply (x^2 * x^4 * ... * x^128 = x^254; 0 maps to 0), then affine
   always_comb begin
      pw  = in_byte;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         pw  = gf_mul(pw, pw);
         inv = gf_mul(inv, pw);
      end
      out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end

endmodule

module aes128_enc_iter (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } fsm_t;

   fsm_t         fsm_q,   fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] key_q,   key_d;
   logic [7:0]   rcon_q,  rcon_d;
   logic [3:0]   round_q, round_d;

   logic [127:0] sub_bytes;
   logic [127:0] shift_rows;
   logic [127:0] mix_cols;
   logic [127:0] round_out;
   logic [127:0] next_key;
   logic [31:0]  rot_word;
   logic [31:0]  sub_word;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // RotWord of the last key word feeds the SubWord S-boxes
   assign rot_word = {key_q[23:0], key_q[31:24]};

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub
         aes_sbox u_sbox (
            .in_byte  (state_q[127-8*gi -: 8]),
            .out_byte (sub_bytes[127-8*gi -: 8])
         );
         // Byte gi sits at (row gi%4, col gi/4) and takes (row, col (col+row)%4)
         assign shift_rows[127-8*gi -: 8] =
            sub_bytes[127-8*(4*(((gi/4)+(gi%4))%4) + (gi%4)) -: 8];
      end
      for (gi = 0; gi < 4; gi++) begin : g_mix
         assign mix_cols[127-32*gi -: 32] = mix_column(shift_rows[127-32*gi -: 32]);
      end
      for (gi = 0; gi < 4; gi++) begin : g_subw
         aes_sbox u_sbox (
            .in_byte  (rot_word[31-8*gi -: 8]),
            .out_byte (sub_word[31-8*gi -: 8])
         );
      end
   endgenerate

   // Next round key: chained XOR across the four words
   assign next_key[127:96] = key_q[127:96] ^ sub_word ^ {rcon_q, 24'h000000};
   assign next_key[95:64]  = key_q[95:64]  ^ next_key[127:96];
   assign next_key[63:32]  = key_q[63:32]  ^ next_key[95:64];
   assign next_key[31:0]   = key_q[31:0]   ^ next_key[63:32];

   // Final round skips MixColumns
   assign round_out = (round_q == 4'd10) ? shift_rows : mix_cols;

   // Next-state logic: accept in IDLE, one round per edge in RUN, hold result in DONE
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      rcon_d  = rcon_q;
      round_d = round_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               state_d = in_data ^ in_key;
               key_d   = in_key;
               rcon_d  = 8'h01;
               round_d = 4'd1;
               fsm_d   = RUN;
            end
         end
         RUN: begin
            state_d = round_out ^ next_key;
            key_d   = next_key;
            rcon_d  = xtime(rcon_q);
            if (round_q == 4'd10) begin
               fsm_d = DONE;
            end else begin
               round_d = round_q + 4'd1;
            end
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         state_q <= 128'h0;
         key_q   <= 128'h0;
         rcon_q  <= 8'h00;
         round_q <= 4'd0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         rcon_q  <= rcon_d;
         round_q <= round_d;
      end
   end

   assign in_ready  = (fsm_q == IDLE);
   assign out_valid = (fsm_q == DONE);
   assign out_data  = state_q;

endmodule

// File: doc/aes128_enc_iter.md
# aes128_enc_iter

Iterative AES-128 encryption core: accepts one 128-bit plaintext block and a 128-bit cipher key, executes one full round per clock (SubBytes, forward ShiftRows, MixColumns, AddRoundKey) with on-the-fly key expansion, and returns the ciphertext over a valid/ready handshake. It is the encrypt-side counterpart of the existing inverse-round datapath. It uses the same 128-bit state packing, so blocks produced here decrypt directly on the inverse path. It sits between the block-mode controller and the output buffer.

## Interface
- No parameters (AES-128 only; Nk=4, Nr=10 fixed).
- clk  input  1  sole clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  plaintext/key present.
- in_ready  output  1  core idle, will accept on this edge if in_valid.
- in_data  input  128  plaintext block.
- in_key  input  128  cipher key.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  downstream accepts ciphertext.
- out_data  output  128  ciphertext block.

## Operation
- State packing: word c = bits [127-32c : 96-32c] is column c; within a word, bits [31:24] are row 0 and [7:0] are row 3. The same packing applies to in_data, in_key, out_data and the round-key register.
- Forward ShiftRows: output byte (row r, col c) = input byte (row r, col (c+r) mod 4); row 0 is unshifted and row r rotates left by r.
- MixColumns: standard GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2], polynomial 0x11B. Omitted in round 10.
- SubBytes uses 16 instances of the team's existing forward S-box. The key schedule uses 4 more for SubWord.
- Key expansion on the fly: next key w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. It is an 8-bit register doubled with xtime each round.
- FSM states:
  - IDLE: in_ready=1. On in_valid the core captures state <= in_data ^ in_key, key <= in_key, rcon <= 8'h01, round <= 1, and moves to RUN.
  - RUN: each edge computes next key from (key, rcon), then state <= round(state) ^ nextkey, key <= nextkey, rcon <= xtime(rcon), round <= round+1. When round==10 the edge applies the final round (no MixColumns) and moves to DONE.
  - DONE: out_valid=1 and out_data=state, held stable. On out_ready the core moves to IDLE.
- Round counter is 4 bits, values 1..10; it never wraps.
- in_valid is ignored outside IDLE. in_data and in_key are sampled only at the acceptance edge and may change afterwards.
- in_ready and out_valid are decoded from state registers only; there is no combinational path from any input.
- Decoding of unused FSM encodings forces IDLE.

## Timing
- Reset (asynchronous assert, any state including mid-RUN): state=IDLE, in_ready=1, out_valid=0, out_data=0, round=0, rcon=0, key=0.
- Acceptance edge T0: in_valid & in_ready sampled high.
- RUN occupies edges T1..T10. out_valid is high from just after T10, giving latency 10 cycles from acceptance to out_valid.
- Output handshake: if out_ready is high at edge Tk (k≥11), out_valid drops after Tk and in_ready rises after Tk. The next acceptance is at the earliest Tk+1.
- Throughput: one block per 12 cycles with out_ready held high.
- out_data holds its value while out_valid=1 and out_ready=0, for an unbounded time.
- No simultaneous accept and output in the same cycle; the handshakes are mutually exclusive by state.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1 → out_valid exactly 10 cycles after acceptance, out_data 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a. Also check the internal round-1 state after T1 equals 89d810e8855ace682d1843d8cb128fe4.
- Backpressure: out_ready low for 7 cycles after out_valid rises → out_data stable and in_ready=0 throughout; drop of out_valid on the first high out_ready edge, then in_ready=1.
- Back-to-back: App. B then App. C.1 with in_valid held high and out_ready=1 → second acceptance 12 cycles after the first, both ciphertexts correct.
- Busy-ignore: during RUN, pulse in_valid with a different key/pt and change in_data → first result unaffected and no extra output block.
- Reset mid-run: assert rst_n=0 asynchronously between T5 and T6 → in_ready=1, out_valid=0, out_data=0 immediately. After release, a fresh App. B run produces the correct ciphertext.
